// File: rtl/rbot_moves_pkg.sv
// Move codes and helpers shared by spin_all, move_queue and the motor sequencer.
// Codes 0 and 1 are "no move" fillers inside packed batches.
package rbot_moves_pkg;

    localparam int MOVE_W = 4;

    localparam logic [MOVE_W-1:0] MV_NOP = 4'd0;
    localparam logic [MOVE_W-1:0] MV_R   = 4'd2;
    localparam logic [MOVE_W-1:0] MV_RI  = 4'd3;
    localparam logic [MOVE_W-1:0] MV_U   = 4'd4;
    localparam logic [MOVE_W-1:0] MV_UI  = 4'd5;
    localparam logic [MOVE_W-1:0] MV_F   = 4'd6;
    localparam logic [MOVE_W-1:0] MV_FI  = 4'd7;
    localparam logic [MOVE_W-1:0] MV_L   = 4'd8;
    localparam logic [MOVE_W-1:0] MV_LI  = 4'd9;
    localparam logic [MOVE_W-1:0] MV_B   = 4'd10;
    localparam logic [MOVE_W-1:0] MV_BI  = 4'd11;
    localparam logic [MOVE_W-1:0] MV_D   = 4'd12;
    localparam logic [MOVE_W-1:0] MV_DI  = 4'd13;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_UNPACK
    } mq_state_e;

    function automatic logic is_move(input logic [MOVE_W-1:0] code);
        return |code[MOVE_W-1:1];
    endfunction

endpackage

// File: rtl/move_queue_if.sv
// Batch input and move handshake between controller, move_queue and motor sequencer.
// master = controller/sequencer side, slave = move_queue.
interface move_queue_if #(
    parameter int SLOTS = 15
);

    logic [4*SLOTS-1:0] moves;
    logic               new_moves;
    logic               move_ready;
    logic [3:0]         move;
    logic               move_valid;
    logic               busy;
    logic               batch_drained;
    logic               overflow;

    modport master (
        output moves,
        output new_moves,
        output move_ready,
        input  move,
        input  move_valid,
        input  busy,
        input  batch_drained,
        input  overflow
    );

    modport slave (
        input  moves,
        input  new_moves,
        input  move_ready,
        output move,
        output move_valid,
        output busy,
        output batch_drained,
        output overflow
    );

endinterface

// File: rtl/move_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible while non-empty.
// A push into a full FIFO is taken only together with a pop.
module move_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/move_queue.sv
// Unpacks 60-bit move batches into single move codes, highest slot first,
// and hands them to the motor sequencer through a FWFT queue.
module move_queue
    import rbot_moves_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int SLOTS = 15
) (
    input logic         clock,
    input logic         reset,
    move_queue_if.slave bus
);

    localparam int WW  = MOVE_W * SLOTS;
    localparam int SCW = $clog2(SLOTS+1);
    localparam int CW  = $clog2(DEPTH+1);

    logic              new_q;
    logic [WW-1:0]     moves_q;
    mq_state_e         state_q;
    mq_state_e         state_d;
    logic [WW-1:0]     shreg_q;
    logic [WW-1:0]     shreg_d;
    logic [SCW-1:0]    slots_q;
    logic [SCW-1:0]    slots_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              act_q;
    logic              act;
    logic              load;
    logic              push;
    logic              pop;
    logic              advance;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [MOVE_W-1:0] top;
    logic [MOVE_W-1:0] head;

    assign top  = shreg_q[WW-1 -: MOVE_W];
    assign pop  = ~empty & bus.move_ready;
    assign load = new_q & (state_q == ST_IDLE);

    // Strobe and batch are registered once before the FSM sees them.
    always_ff @(posedge clock) begin
        if (reset) begin
            new_q   <= 1'b0;
            moves_q <= '0;
        end else begin
            new_q <= bus.new_moves;
            if (bus.new_moves) begin
                moves_q <= bus.moves;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load && moves_q != '0) begin
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                if (advance && slots_q == SCW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push    = 1'b0;
        advance = 1'b0;
        shreg_d = shreg_q;
        slots_d = slots_q;
        ovf_d   = ovf_q | (new_q & (state_q == ST_UNPACK));
        if (state_q == ST_UNPACK) begin
            if (!is_move(top)) begin
                advance = 1'b1;
            end else if (!full || pop) begin
                push    = 1'b1;
                advance = 1'b1;
            end
        end
        if (load) begin
            shreg_d = moves_q;
            slots_d = SCW'(SLOTS);
        end else if (advance) begin
            shreg_d = shreg_q << MOVE_W;
            slots_d = slots_q - SCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q <= '0;
            slots_q <= '0;
            ovf_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            slots_q <= slots_d;
            ovf_q   <= ovf_d;
            act_q   <= act;
        end
    end

    move_fifo #(
        .WIDTH (MOVE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .data_i  (top),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A pending strobe keeps the queue active, so no drain pulse fires under it.
    assign act = (state_q != ST_IDLE) | (count != '0) | new_q;

    assign bus.move_valid    = ~empty;
    assign bus.move          = empty ? MV_NOP : head;
    assign bus.busy          = act;
    assign bus.batch_drained = act_q & ~act;
    assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_move_queue.sv
// Directed bench for move_queue: ordering, stalls, overflow, drain pulse, reset.
// The DUT is built with a 16-entry queue so the full-stall case is reachable.
module tb_move_queue;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    move_queue_if #(.SLOTS(15)) bus();

    move_queue #(
        .DEPTH (16),
        .SLOTS (15)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] rx[$];
    int drains = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.move_valid && bus.move_ready) begin
                rx.push_back(bus.move);
            end
            if (bus.batch_drained) begin
                drains++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [59:0] w);
        bus.moves     = w;
        bus.new_moves = 1'b1;
        tick(1);
        bus.new_moves = 1'b0;
    endtask

    task automatic clear_mon();
        rx.delete();
        drains = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick(1);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles", budget);
        end
        tick(3);
    endtask

    function automatic logic [3:0] pick(input int i);
        if (i < rx.size()) return rx[i];
        return 4'hx;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks += 5;
        if (bus.move !== 4'd0) begin
            errors++;
            $display("FAIL reset_move got %0d want 0", bus.move);
        end
        if (bus.move_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", bus.move_valid);
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        if (bus.batch_drained !== 1'b0) begin
            errors++;
            $display("FAIL reset_drained got %b want 0", bus.batch_drained);
        end
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got %b want 0", bus.overflow);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        logic [3:0] want[3] = '{4'd8, 4'd3, 4'd7};
        clear_mon();
        bus.move_ready = 1'b1;
        strobe(60'h837);
        wait_idle(60);
        checks++;
        if (rx.size() !== 3) begin
            errors++;
            $display("FAIL basic_count got %0d want 3", rx.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pick(i) !== want[i]) begin
                errors++;
                $display("FAIL basic_move%0d got %0d want %0d", i, pick(i), want[i]);
            end
        end
        checks += 2;
        if (drains !== 1) begin
            errors++;
            $display("FAIL basic_drained got %0d want 1", drains);
        end
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_overflow got %b want 0", bus.overflow);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        int wrong = 0;
        clear_mon();
        bus.move_ready = 1'b0;
        strobe(60'h666666666666666);
        tick(1);
        checks++;
        if (bus.move_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_valid_t2 got %b want 0", bus.move_valid);
        end
        tick(1);
        checks += 2;
        if (bus.move_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_valid_t3 got %b want 1", bus.move_valid);
        end
        if (bus.move !== 4'd6) begin
            errors++;
            $display("FAIL hold_move_t3 got %0d want 6", bus.move);
        end
        for (int i = 0; i < 17; i++) begin
            tick(1);
            if (bus.move_valid !== 1'b1 || bus.move !== 4'd6) bad++;
        end
        checks += 3;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_steady got %0d bad cycles want 0", bad);
        end
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_busy got %b want 1", bus.busy);
        end
        if (rx.size() !== 0) begin
            errors++;
            $display("FAIL hold_no_xfer got %0d want 0", rx.size());
        end
        bus.move_ready = 1'b1;
        wait_idle(60);
        foreach (rx[i]) begin
            if (rx[i] !== 4'd6) wrong++;
        end
        checks += 3;
        if (rx.size() !== 15) begin
            errors++;
            $display("FAIL hold_count got %0d want 15", rx.size());
        end
        if (wrong !== 0) begin
            errors++;
            $display("FAIL hold_values got %0d wrong want 0", wrong);
        end
        if (drains !== 1) begin
            errors++;
            $display("FAIL hold_drained got %0d want 1", drains);
        end
    endtask

    task automatic test_full_stall();
        logic [59:0] wa = 60'h23456789ABCD234;
        logic [59:0] wb = 60'hDCBA98765432DCB;
        logic [3:0] expq[$];
        int wrong = 0;
        for (int k = 14; k >= 0; k--) expq.push_back(wa[4*k +: 4]);
        for (int k = 14; k >= 0; k--) expq.push_back(wb[4*k +: 4]);
        clear_mon();
        bus.move_ready = 1'b0;
        strobe(wa);
        tick(20);
        strobe(wb);
        tick(25);
        checks += 2;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy got %b want 1", bus.busy);
        end
        if (bus.move !== 4'd2) begin
            errors++;
            $display("FAIL stall_head got %0d want 2", bus.move);
        end
        bus.move_ready = 1'b1;
        wait_idle(80);
        for (int i = 0; i < 30; i++) begin
            if (pick(i) !== expq[i]) wrong++;
        end
        checks += 4;
        if (rx.size() !== 30) begin
            errors++;
            $display("FAIL stall_count got %0d want 30", rx.size());
        end
        if (wrong !== 0) begin
            errors++;
            $display("FAIL stall_order got %0d wrong want 0", wrong);
        end
        if (pick(15) !== 4'd13) begin
            errors++;
            $display("FAIL stall_second_first got %0d want 13", pick(15));
        end
        if (drains !== 1) begin
            errors++;
            $display("FAIL stall_drained got %0d want 1", drains);
        end
    endtask

    task automatic test_overflow();
        clear_mon();
        bus.move_ready = 1'b1;
        strobe(60'h2);
        tick(2);
        strobe(60'h3);
        wait_idle(60);
        checks += 3;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b want 1", bus.overflow);
        end
        if (rx.size() !== 1 || pick(0) !== 4'd2) begin
            errors++;
            $display("FAIL ovf_stream got size %0d first %0d want 1/2", rx.size(), pick(0));
        end
        if (drains !== 1) begin
            errors++;
            $display("FAIL ovf_drained got %0d want 1", drains);
        end
        tick(5);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", bus.overflow);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.overflow);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_zero();
        clear_mon();
        bus.move_ready = 1'b1;
        strobe(60'h0);
        checks++;
        if (bus.batch_drained !== 1'b0) begin
            errors++;
            $display("FAIL zero_t1 got %b want 0", bus.batch_drained);
        end
        tick(1);
        checks++;
        if (bus.batch_drained !== 1'b1) begin
            errors++;
            $display("FAIL zero_t2 got %b want 1", bus.batch_drained);
        end
        tick(1);
        checks++;
        if (bus.batch_drained !== 1'b0) begin
            errors++;
            $display("FAIL zero_t3 got %b want 0", bus.batch_drained);
        end
        tick(5);
        checks += 2;
        if (rx.size() !== 0) begin
            errors++;
            $display("FAIL zero_moves got %0d want 0", rx.size());
        end
        if (drains !== 1) begin
            errors++;
            $display("FAIL zero_drained got %0d want 1", drains);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        bus.move_ready = 1'b0;
        strobe(60'h23456789ABCD234);
        tick(8);
        checks++;
        if (bus.move_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid got %b want 1", bus.move_valid);
        end
        rst = 1'b1;
        tick(1);
        checks += 4;
        if (bus.move_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_valid got %b want 0", bus.move_valid);
        end
        if (bus.move !== 4'd0) begin
            errors++;
            $display("FAIL mid_move got %0d want 0", bus.move);
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy got %b want 0", bus.busy);
        end
        if (bus.batch_drained !== 1'b0) begin
            errors++;
            $display("FAIL mid_drained got %b want 0", bus.batch_drained);
        end
        rst = 1'b0;
        bus.move_ready = 1'b1;
        tick(25);
        checks += 2;
        if (rx.size() !== 0) begin
            errors++;
            $display("FAIL mid_stale got %0d moves want 0", rx.size());
        end
        if (drains !== 0) begin
            errors++;
            $display("FAIL mid_pulse got %0d want 0", drains);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.moves      = '0;
        bus.new_moves  = 1'b0;
        bus.move_ready = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_full_stall();
        test_overflow();
        test_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
